rram_uart_tx: RTL and testbench

- Downstream serial stage for the RRAM controller.
- Captures the controller's 64-bit word (header or cell dump) on a one-cycle `tx_en` strobe.
- Transmits it over a UART line as 8 bytes, most-significant byte first, 8N1 framing.
- Holds `tx_dv` high while busy; the controller stalls in its serial-wait states on `tx_dv`.

---
 rtl/rram_uart_tx.sv | 208 ++++++++++++++++++++
 tb/tb_rram_uart_tx.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rram_uart_tx.sv
// rram_uart_tx -- serial output stage of the RRAM controller.
//
// Captures a 64-bit word on a one-cycle tx_en strobe and sends its top
// NUM_BYTES bytes over a UART line, most-significant byte first. Each byte
// is an 8N1 frame (start bit, 8 data bits LSB first, STOP_BITS stop bits).
// Bytes follow each other with no idle gap. A one-cycle DONE state closes
// the word.
//
// Optional feature: define RRAM_UART_PARITY_EN to insert an even-parity bit
// after the data bits of every byte. The frame then grows by one bit time.
//
// Handshake: tx_en is a one-cycle request. It is accepted only when the FSM
// is IDLE. tx_dv is the busy flag. It reads 1 combinationally in the cycle
// tx_en is accepted, and it stays 1 until the cycle after DONE. A tx_en
// seen while tx_dv is already high from an earlier word is dropped.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   tx_en      one-cycle strobe: capture tx_reg and start sending
//   tx_reg     word to send; byte [63:56] goes out first
//   tx_dv      busy flag (combinational with tx_en while IDLE)
//   tx_serial  UART line, registered, idles high
//   tx_done    registered one-cycle pulse during the DONE state
//   fsm_state  current FSM state, for debug and checker binding

module rram_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int NUM_BYTES    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_en,
  input  logic [63:0] tx_reg,
  output logic        tx_dv,
  output logic        tx_serial,
  output logic        tx_done,
  output logic [2:0]  fsm_state
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

`ifdef RRAM_UART_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    DONE   = 3'd4,
    PARITY = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } state_t;
`endif

  state_t              state, state_n;
  logic [BAUD_W-1:0]   baud_cnt, baud_n;
  logic [2:0]          bit_cnt, bit_n;
  logic [2:0]          byte_cnt, byte_n;
  logic                stop_cnt, stop_n;
  logic [63:0]         shreg, shreg_n;
  logic                busy_reg, busy_n;
  logic                serial_n;
  logic                done_n;
  logic                baud_last;
  logic [7:0]          next_byte;

  assign baud_last = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
  assign tx_dv     = busy_reg | (tx_en & (state == IDLE));
  assign fsm_state = state;

  // Next-state logic. Every bit-time transition happens on the terminal
  // baud count, so each line level is held for exactly CLKS_PER_BIT cycles.
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    byte_n  = byte_cnt;
    stop_n  = stop_cnt;
    shreg_n = shreg;
    busy_n  = busy_reg;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (tx_en) begin
          shreg_n = tx_reg;
          byte_n  = '0;
          bit_n   = '0;
          baud_n  = '0;
          busy_n  = 1'b1;
          state_n = START;
        end
      end
      START: begin
        if (baud_last) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = DATA;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_n = '0;
          if (bit_cnt == 3'd7) begin
            stop_n  = 1'b0;
`ifdef RRAM_UART_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
`ifdef RRAM_UART_PARITY_EN
      PARITY: begin
        if (baud_last) begin
          baud_n  = '0;
          stop_n  = 1'b0;
          state_n = STOP;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
`endif
      STOP: begin
        if (baud_last) begin
          baud_n = '0;
          if (stop_cnt == 1'(STOP_BITS - 1)) begin
            if (byte_cnt == 3'(NUM_BYTES - 1)) begin
              state_n = DONE;
              done_n  = 1'b1;
            end else begin
              // The next byte always sits in the top lane of the shifter.
              shreg_n = {shreg[55:0], 8'h00};
              byte_n  = byte_cnt + 1'b1;
              state_n = START;
            end
          end else begin
            stop_n = stop_cnt + 1'b1;
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      DONE: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  // The line level is computed from the state being entered. Registering it
  // lines tx_serial up with the state register and keeps the line glitch-free.
  always_comb begin
    next_byte = shreg_n[63:56];
    serial_n  = 1'b1;
    case (state_n)
      START:   serial_n = 1'b0;
      DATA:    serial_n = next_byte[bit_n];
`ifdef RRAM_UART_PARITY_EN
      PARITY:  serial_n = ^next_byte;
`endif
      default: serial_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      stop_cnt  <= 1'b0;
      shreg     <= '0;
      busy_reg  <= 1'b0;
      tx_serial <= 1'b1;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_n;
      bit_cnt   <= bit_n;
      byte_cnt  <= byte_n;
      stop_cnt  <= stop_n;
      shreg     <= shreg_n;
      busy_reg  <= busy_n;
      tx_serial <= serial_n;
      tx_done   <= done_n;
    end
  end

endmodule

// File: tb/tb_rram_uart_tx.sv
// Testbench for rram_uart_tx with CLKS_PER_BIT=4, NUM_BYTES=8, STOP_BITS=1.
// The reference model expands each word into its ideal UART bit sequence.
// It checks the line bit time by bit time, along with the busy window and
// the done pulse. An independent UART receiver decodes the line into bytes,
// and those bytes are scoreboarded against the bytes expected per word.

module tb_rram_uart_tx;

  localparam int CPB = 4;
  localparam int NB  = 8;
  localparam int SB  = 1;

  logic        clk;
  logic        rst;
  logic        tx_en;
  logic [63:0] tx_reg;
  logic        tx_dv;
  logic        tx_serial;
  logic        tx_done;
  logic [2:0]  fsm_state;

  int n_vec = 0;
  int n_err = 0;
  int word_id = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         rx_frame_err = 0;

  rram_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .NUM_BYTES   (NB),
    .STOP_BITS   (SB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_en    (tx_en),
    .tx_reg   (tx_reg),
    .tx_dv    (tx_dv),
    .tx_serial(tx_serial),
    .tx_done  (tx_done),
    .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- comparison ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- independent UART receiver ----------------
  // Detects a start bit, then samples each later bit in the middle of its
  // bit time.
  initial begin : rx_mon
    logic [7:0] b;
    logic       s;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && tx_serial === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(negedge clk);
          b[k] = tx_serial;
        end
`ifdef RRAM_UART_PARITY_EN
        repeat (CPB) @(negedge clk);
        if (tx_serial !== ^b) rx_frame_err++;
`endif
        for (int k = 0; k < SB; k++) begin
          repeat (CPB) @(negedge clk);
          s = tx_serial;
          if (s !== 1'b1) rx_frame_err++;
        end
        rx_q.push_back(b);
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check_rx();
    logic [7:0] e;
    logic [7:0] o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rx_q.size() > 0) o = rx_q.pop_front();
      else o = 8'hxx;
      chk($sformatf("rx_byte w%0d", word_id), {56'd0, o}, {56'd0, e});
    end
    chk("rx_extra_bytes", rx_q.size(), 0);
    chk("rx_frame_err", rx_frame_err, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- driver + reference model ----------------
  // Each send starts on a negedge, so the cycle it first drives tx_en is the
  // capture cycle. t counts cycles after that capture cycle.
  // abort_at > 0 pulls reset in cycle t == abort_at.
  // inject_at > 0 raises a second tx_en with a different word in that cycle.
  task automatic send_word(input logic [63:0] w, input int abort_at, input int inject_at);
    bit          eb[$];
    logic [7:0]  by;
    logic [CPB-1:0] samp;
    logic [CPB-1:0] want;
    logic        ebit;
    int          total;
    int          dv_cnt;
    int          done_cnt;
    int          done_at;
    int          bad;
    bit          dv_run;

    for (int i = 0; i < NB; i++) begin
      by = w[63 - 8 * i -: 8];
      eb.push_back(1'b0);
      for (int k = 0; k < 8; k++) eb.push_back(by[k]);
`ifdef RRAM_UART_PARITY_EN
      eb.push_back(^by);
`endif
      for (int s = 0; s < SB; s++) eb.push_back(1'b1);
      if (abort_at == 0) exp_q.push_back(by);
    end
    total = eb.size() * CPB;
    word_id++;

    @(negedge clk);
    chk("idle_serial", tx_serial, 1);
    chk("idle_dv", tx_dv, 0);
    chk("idle_done", tx_done, 0);
    tx_reg = w;
    tx_en  = 1'b1;
    #1;
    chk("dv_with_en", tx_dv, 1);

    dv_cnt = 0; dv_run = 1'b1; done_cnt = 0; done_at = 0;
    for (int t = 1; t <= total + 1; t++) begin
      @(negedge clk);
      if (tx_dv === 1'b1 && dv_run) dv_cnt++;
      else dv_run = 1'b0;
      if (tx_done === 1'b1) begin
        done_cnt++;
        done_at = t;
      end
      if (t <= total) begin
        samp[(t - 1) % CPB] = tx_serial;
        if ((t - 1) % CPB == CPB - 1) begin
          ebit = eb[(t - 1) / CPB];
          want = {CPB{ebit}};
          chk($sformatf("line w%0d bit%0d", word_id, (t - 1) / CPB),
              {{(64 - CPB){1'b0}}, samp}, {{(64 - CPB){1'b0}}, want});
        end
      end else begin
        chk("done_cycle_line", tx_serial, 1);
      end

      tx_en = (inject_at > 0 && t == inject_at);
      if (inject_at > 0 && t == inject_at) tx_reg = ~w;

      if (t == abort_at) begin
        #2 rst = 1'b0;
        #1;
        chk("abort_serial", tx_serial, 1);
        chk("abort_dv", tx_dv, 0);
        chk("abort_done", tx_done, 0);
        bad = 0;
        repeat (5) begin
          @(negedge clk);
          if (tx_done !== 1'b0 || tx_serial !== 1'b1 || tx_dv !== 1'b0) bad++;
        end
        rst = 1'b1;
        bad += (tx_done !== 1'b0) ? 1 : 0;
        chk("abort_hold_quiet", bad, 0);
        return;
      end
    end

    chk("dv_cycles_after_en", dv_cnt, total + 1);
    chk("done_pulses", done_cnt, 1);
    chk("done_cycle", done_at, total + 1);
    check_rx();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst    = 1'b1;
    tx_en  = 1'b0;
    tx_reg = 64'd0;
    #1 rst = 1'b0;
    #1;
    chk("reset_serial", tx_serial, 1);
    chk("reset_dv", tx_dv, 0);
    chk("reset_done", tx_done, 0);
    $display("info: fsm_state code during reset = %0d", fsm_state);
    idle(3);
    rst = 1'b1;
    idle(2);

    // Header word
    send_word(64'h0D0A5252414D0D0A, 0, 0);
    idle(3);

    // Busy handshake: a second strobe 50 cycles in must be ignored
    send_word({$urandom(), $urandom()}, 0, 50);
    idle(5);

    // Cell dump
    send_word(64'hFFFFFFFF00000001, 0, 0);
    idle(2);

    // Back-to-back: the second strobe lands in the first IDLE cycle
    send_word({$urandom(), $urandom()}, 0, 0);
    send_word({$urandom(), $urandom()}, 0, 0);
    idle(4);

    // Reset in the middle of byte 3's data bits (cycle 135 of the word)
    send_word({$urandom(), $urandom()}, 135, 0);
    idle(15 * CPB);
    rx_q.delete();
    rx_frame_err = 0;

    // A full word from byte 0 after the abort
    send_word({$urandom(), $urandom()}, 0, 0);

    // Random words with random idle gaps
    for (int i = 0; i < 4; i++) begin
      idle($urandom_range(1, 20));
      send_word({$urandom(), $urandom()}, 0, 0);
    end
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
